counter_ctrl: RTL and testbench

- Parametrised up/down counter, successor to the team's 5-bit load/enable counter.
- Adds generic width and modulus, count direction, and three run modes: wrap, saturate and one-shot.
- Adds a terminal-count output and a cascade carry, a sticky overflow flag, and a done flag for one-shot mode.
- Used as the general-purpose event/timer counter in datapath control; multiple instances chain via carry_out -> enab.

---
 rtl/counter_ctrl.sv | 120 ++++++++++++
 tb/tb_counter_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : counter_ctrl
// Brief    : Parametrised up/down event counter with wrap, saturate and
//            one-shot modes, terminal count, cascade carry, sticky overflow.
// Revision : 1.0 - initial release
// ============================================================================
module counter_ctrl #(
    parameter int WIDTH   = 5,
    parameter int MAX_VAL = (1 << WIDTH) - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enab,
    input  logic             load,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] cnt_out,
    output logic             tc,
    output logic             carry_out,
    output logic             ovf,
    output logic             done
);

    localparam logic [WIDTH-1:0] c_max  = MAX_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] c_zero = '0;

    localparam logic [1:0] c_mode_wrap = 2'b00;
    localparam logic [1:0] c_mode_sat  = 2'b01;
    localparam logic [1:0] c_mode_one  = 2'b10;

    localparam logic [0:0] c_st_run  = 1'b0;
    localparam logic [0:0] c_st_halt = 1'b1;

    generate
        if (WIDTH < 2 || MAX_VAL < 1 || MAX_VAL > (1 << WIDTH) - 1) begin : g_bad_param
            $error("counter_ctrl: illegal WIDTH/MAX_VAL combination");
        end
    endgenerate

    logic [WIDTH-1:0] r_cnt;
    logic [0:0]       r_state;
    logic             r_ovf;
    logic             r_done;

    logic [WIDTH-1:0] w_tv;
    logic             w_tc;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic [0:0]       w_state_nxt;
    logic             w_done_nxt;
    logic             w_ovf_set;

    assign w_tv      = dir ? c_max : c_zero;
    assign w_tc      = (r_cnt == w_tv);
    assign tc        = w_tc;
    assign carry_out = w_tc & enab & ~load & (r_state == c_st_run);
    assign cnt_out   = r_cnt;
    assign ovf       = r_ovf;
    assign done      = r_done;

    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_state_nxt = r_state;
        w_done_nxt  = r_done;
        w_ovf_set   = 1'b0;
        if (load) begin
            // Out-of-range loads clamp silently; they are not overflows.
            w_cnt_nxt   = (cnt_in > c_max) ? c_max : cnt_in;
            w_state_nxt = c_st_run;
            w_done_nxt  = 1'b0;
        end else if (r_state == c_st_halt) begin
            if (mode != c_mode_one) begin
                w_state_nxt = c_st_run;
                w_done_nxt  = 1'b0;
            end
        end else if (enab) begin
            if (!w_tc) begin
                w_cnt_nxt = dir ? (r_cnt + c_one) : (r_cnt - c_one);
            end else begin
                case (mode)
                    c_mode_sat: begin
                        w_ovf_set = 1'b1;
                    end
                    c_mode_one: begin
                        w_state_nxt = c_st_halt;
                        w_done_nxt  = 1'b1;
                    end
                    default: begin
                        // Wrap mode; the reserved encoding also lands here.
                        w_cnt_nxt = dir ? c_zero : c_max;
                        w_ovf_set = 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= c_zero;
            r_state <= c_st_run;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
            // A set in the same cycle as a clear wins.
            r_ovf   <= w_ovf_set | (r_ovf & ~ovf_clr);
        end
    end

    logic w_unused_mode;
    assign w_unused_mode = (mode == c_mode_wrap);

endmodule
`default_nettype wire

// File: tb/tb_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_ctrl
// Brief    : Scoreboard bench for counter_ctrl (main instance plus cascade).
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_ctrl;

    logic       clk = 1'b0;
    logic       rst, enab, load, dir, ovf_clr;
    logic [1:0] mode;
    logic [4:0] cnt_in;
    logic [4:0] cnt_out;
    logic       tc, carry_out, ovf, done;

    logic       c_enab;
    logic [4:0] lo_cnt, hi_cnt;
    logic       lo_tc, lo_carry, lo_ovf, lo_done;
    logic       hi_tc, hi_carry, hi_ovf, hi_done;

    always #5 clk = ~clk;

    counter_ctrl #(.WIDTH(5), .MAX_VAL(23)) u_dut (
        .clk(clk), .rst(rst), .enab(enab), .load(load), .dir(dir), .mode(mode),
        .cnt_in(cnt_in), .ovf_clr(ovf_clr), .cnt_out(cnt_out), .tc(tc),
        .carry_out(carry_out), .ovf(ovf), .done(done)
    );

    counter_ctrl #(.WIDTH(5), .MAX_VAL(9)) u_lo (
        .clk(clk), .rst(rst), .enab(c_enab), .load(1'b0), .dir(1'b1), .mode(2'b00),
        .cnt_in(5'd0), .ovf_clr(1'b0), .cnt_out(lo_cnt), .tc(lo_tc),
        .carry_out(lo_carry), .ovf(lo_ovf), .done(lo_done)
    );

    counter_ctrl #(.WIDTH(5), .MAX_VAL(9)) u_hi (
        .clk(clk), .rst(rst), .enab(lo_carry), .load(1'b0), .dir(1'b1), .mode(2'b00),
        .cnt_in(5'd0), .ovf_clr(1'b0), .cnt_out(hi_cnt), .tc(hi_tc),
        .carry_out(hi_carry), .ovf(hi_ovf), .done(hi_done)
    );

    typedef struct {
        string      name;
        bit         kind;   // 0 = main instance, 1 = cascade pair
        logic [4:0] cnt;
        logic [4:0] hi;
        logic       tc;
        logic       carry;
        logic       ovf;
        logic       done;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic cmp(input string n, input logic [4:0] act, input logic [4:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", n, act, req);
        end
    endtask

    // Entries are pushed just after a rising edge and consumed on the
    // following falling edge, so each describes what the DUT shows then.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            if (e.kind == 1'b0) begin
                cmp({e.name, ".cnt"},   cnt_out,            e.cnt);
                cmp({e.name, ".tc"},    {4'd0, tc},         {4'd0, e.tc});
                cmp({e.name, ".carry"}, {4'd0, carry_out},  {4'd0, e.carry});
                cmp({e.name, ".ovf"},   {4'd0, ovf},        {4'd0, e.ovf});
                cmp({e.name, ".done"},  {4'd0, done},       {4'd0, e.done});
            end else begin
                cmp({e.name, ".lo"}, lo_cnt, e.cnt);
                cmp({e.name, ".hi"}, hi_cnt, e.hi);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_main(input string n, input logic [4:0] c, input logic t,
                            input logic cy, input logic o, input logic d);
        exp_t e;
        e.name = n; e.kind = 1'b0; e.cnt = c; e.hi = 5'd0;
        e.tc = t; e.carry = cy; e.ovf = o; e.done = d;
        q.push_back(e);
    endtask

    task automatic exp_cas(input string n, input logic [4:0] l, input logic [4:0] h);
        exp_t e;
        e.name = n; e.kind = 1'b1; e.cnt = l; e.hi = h;
        e.tc = 1'b0; e.carry = 1'b0; e.ovf = 1'b0; e.done = 1'b0;
        q.push_back(e);
    endtask

    initial begin
        rst = 1'b0; enab = 1'b0; load = 1'b0; dir = 1'b1; mode = 2'b00;
        cnt_in = 5'd0; ovf_clr = 1'b0; c_enab = 1'b0;
        repeat (3) @(posedge clk);

        // Reset release, count up to 9, then asynchronous reset mid-count.
        tick(); rst = 1'b1; load = 1'b1; cnt_in = 5'd7; enab = 1'b1;
                exp_main("rst_rel", 5'd0, 0, 0, 0, 0);
        tick(); load = 1'b0;
        tick(); exp_main("count8", 5'd8, 0, 0, 0, 0);
        tick(); rst = 1'b0; exp_main("async_rst", 5'd0, 0, 0, 0, 0);
        tick(); rst = 1'b1; enab = 1'b0;
        tick(); tick(); tick(); exp_main("hold", 5'd0, 0, 0, 0, 0);

        // Wrap up from 21.
        tick(); load = 1'b1; cnt_in = 5'd21;
        tick(); load = 1'b0; enab = 1'b1; exp_main("load21", 5'd21, 0, 0, 0, 0);
        tick(); exp_main("up22",  5'd22, 0, 0, 0, 0);
        tick(); exp_main("up23",  5'd23, 1, 1, 0, 0);
        tick(); exp_main("wrap0", 5'd0,  0, 0, 1, 0);
        tick(); enab = 1'b0; exp_main("wrap1", 5'd1, 0, 0, 1, 0);

        // Saturate down with ovf_clr interplay.
        tick(); ovf_clr = 1'b1; load = 1'b1; cnt_in = 5'd2; mode = 2'b01; dir = 1'b0;
                exp_main("pre_sat", 5'd1, 0, 0, 1, 0);
        tick(); ovf_clr = 1'b0; load = 1'b0; enab = 1'b1;
                exp_main("sat_load", 5'd2, 0, 0, 0, 0);
        tick(); exp_main("down1", 5'd1, 0, 0, 0, 0);
        tick(); exp_main("down0", 5'd0, 1, 1, 0, 0);
        tick(); ovf_clr = 1'b1; exp_main("sat_hold", 5'd0, 1, 1, 1, 0);
        tick(); ovf_clr = 1'b0; exp_main("set_wins", 5'd0, 1, 1, 1, 0);
        tick(); enab = 1'b0; ovf_clr = 1'b1; exp_main("sat_hold2", 5'd0, 1, 0, 1, 0);
        tick(); ovf_clr = 1'b0; exp_main("ovf_clr", 5'd0, 1, 0, 0, 0);

        // One-shot from 20.
        tick(); load = 1'b1; cnt_in = 5'd20; mode = 2'b10; dir = 1'b1; enab = 1'b1;
        tick(); load = 1'b0; exp_main("os20", 5'd20, 0, 0, 0, 0);
        tick(); tick(); tick(); exp_main("os23", 5'd23, 1, 1, 0, 0);
        tick(); exp_main("os_done", 5'd23, 1, 0, 0, 1);
        tick(); exp_main("os_halt", 5'd23, 1, 0, 0, 1);
        tick(); load = 1'b1; cnt_in = 5'd5;
        tick(); load = 1'b0; exp_main("os_reload", 5'd5, 0, 0, 0, 0);
        tick(); enab = 1'b0; exp_main("os_resume", 5'd6, 0, 0, 0, 0);

        // Load priority over enable, with clamp.
        tick(); load = 1'b1; cnt_in = 5'd30; mode = 2'b00;
        tick(); enab = 1'b1; exp_main("clamp", 5'd23, 1, 0, 0, 0);
        tick(); load = 1'b0; enab = 1'b0; exp_main("clamp_hold", 5'd23, 1, 0, 0, 0);

        // Cascade: 25 enabled steps on the low decade counter.
        tick(); c_enab = 1'b1;
        repeat (9) tick();
        tick(); exp_cas("cas10", 5'd0, 5'd1);
        repeat (14) tick();
        tick(); c_enab = 1'b0; exp_cas("cas25", 5'd5, 5'd2);

        tick(); tick();
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain: %0d entries left, expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time limit");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
